// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-memory interface.
//
// This unit accepts one load or store at a time from the MEM stage and drives datamem.
// Loads return their data, with the destination tag, to writeback once the fixed memory
// latency has elapsed. Addresses at or above MEM_DEPTH are rejected without any memory strobe.
//
// Ports:
//   clk, rst                 clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready      request handshake; req_ready is high only in idle
//   req_write                1 = store, 0 = load
//   req_addr/wdata/tag       word address, store data and load destination tag
//   mem_address/datawrite    address and write data to datamem (hold outside active cycles)
//   mem_memwrite/memread     one-cycle write strobe, MEM_LAT-cycle read strobe
//   mem_readdata             read data from datamem
//   resp_valid/resp_ready    load response handshake
//   resp_data/tag/err        load result; on an out-of-range load, err is 1 and data is 0
//   store_err                one-cycle pulse when an out-of-range store is dropped
//   busy                     high whenever the FSM is not idle
module mem_access_unit #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MEM_DEPTH = 100,
   parameter int unsigned MEM_LAT   = 1,
   parameter int unsigned TAG_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [TAG_W-1:0]  req_tag,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_datawrite,
   output logic              mem_memwrite,
   output logic              mem_memread,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              resp_err,
   output logic              store_err,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StWrite, StReadWait, StResp} state_t;

   localparam logic [2:0] LatInit = 3'(MEM_LAT - 1);
   // One extra bit, so that a depth of 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(MEM_DEPTH);

   state_t     state;
   logic [2:0] lat_cnt;
   logic       accept;
   logic       in_range;

   assign accept   = req_valid & req_ready;
   assign in_range = {1'b0, req_addr} < DepthLim;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         lat_cnt       <= '0;
         req_ready     <= 1'b1;
         mem_address   <= '0;
         mem_datawrite <= '0;
         mem_memwrite  <= 1'b0;
         mem_memread   <= 1'b0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         resp_tag      <= '0;
         resp_err      <= 1'b0;
         store_err     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         store_err <= 1'b0;
         case (state)
            StIdle: begin
               if (accept) begin
                  if (req_write) begin
                     if (in_range) begin
                        state         <= StWrite;
                        mem_address   <= req_addr;
                        mem_datawrite <= req_wdata;
                        mem_memwrite  <= 1'b1;
                        req_ready     <= 1'b0;
                        busy          <= 1'b1;
                     end else begin
                        // Dropped store: stay idle and keep accepting requests.
                        store_err <= 1'b1;
                     end
                  end else begin
                     resp_tag  <= req_tag;
                     req_ready <= 1'b0;
                     busy      <= 1'b1;
                     if (in_range) begin
                        state       <= StReadWait;
                        mem_address <= req_addr;
                        mem_memread <= 1'b1;
                        lat_cnt     <= LatInit;
                     end else begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= '0;
                     end
                  end
               end
            end
            StWrite: begin
               mem_memwrite <= 1'b0;
               state        <= StIdle;
               req_ready    <= 1'b1;
               busy         <= 1'b0;
            end
            StReadWait: begin
               if (lat_cnt == 3'd0) begin
                  resp_data   <= mem_readdata;
                  resp_err    <= 1'b0;
                  resp_valid  <= 1'b1;
                  mem_memread <= 1'b0;
                  state       <= StResp;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            StResp: begin
               if (resp_ready) begin
                  state      <= StIdle;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [2:0]  req_tag;
   logic [15:0] mem_address;
   logic [15:0] mem_datawrite;
   logic        mem_memwrite;
   logic        mem_memread;
   logic [15:0] mem_readdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic [2:0]  resp_tag;
   logic        resp_err;
   logic        store_err;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .ADDR_W   (16),
      .DATA_W   (16),
      .MEM_DEPTH(100),
      .MEM_LAT  (3),
      .TAG_W    (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_tag      (req_tag),
      .mem_address  (mem_address),
      .mem_datawrite(mem_datawrite),
      .mem_memwrite (mem_memwrite),
      .mem_memread  (mem_memread),
      .mem_readdata (mem_readdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_tag     (resp_tag),
      .resp_err     (resp_err),
      .store_err    (store_err),
      .busy         (busy)
   );

   // Memory model: data is valid only in the third consecutive memread cycle.
   logic [15:0] mem [100];
   int          rd_run = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          overlap = 0;

   assign mem_readdata = (mem_memread && rd_run == 2 && mem_address < 16'd100)
                         ? mem[mem_address[6:0]] : 16'hDEAD;

   always @(posedge clk) begin
      rd_run <= mem_memread ? rd_run + 1 : 0;
      if (mem_memwrite && mem_address < 16'd100) mem[mem_address[6:0]] <= mem_datawrite;
      if (mem_memwrite) wr_cnt <= wr_cnt + 1;
      if (mem_memread) rd_cnt <= rd_cnt + 1;
      if (mem_memwrite && mem_memread) overlap <= overlap + 1;
   end

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [2:0]  tag;
      logic        oor;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the unit idle again.
   task automatic run_vec(input vec_t v);
      int w0, r0, n;
      w0 = wr_cnt;
      r0 = rd_cnt;
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_tag   = v.tag;
      check("accept_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      if (v.wr) begin
         if (!v.oor) begin
            check("st_memwrite", 32'(mem_memwrite), 32'd1);
            check("st_address", 32'(mem_address), 32'(v.addr));
            check("st_datawrite", 32'(mem_datawrite), 32'(v.wdata));
            check("st_busy", 32'(busy), 32'd1);
            check("st_ready_low", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("st_memwrite_off", 32'(mem_memwrite), 32'd0);
            check("st_ready_back", 32'(req_ready), 32'd1);
            check("st_wr_count", 32'(wr_cnt), 32'(w0 + 1));
         end else begin
            check("st_err_pulse", 32'(store_err), 32'd1);
            check("st_oor_memwrite", 32'(mem_memwrite), 32'd0);
            check("st_oor_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            check("st_err_cleared", 32'(store_err), 32'd0);
            check("st_oor_wr_count", 32'(wr_cnt), 32'(w0));
         end
      end else begin
         n = 0;
         for (int i = 0; i < 20 && !resp_valid; i++) begin
            if (mem_memread) n++;
            @(negedge clk);
         end
         check("ld_resp_valid", 32'(resp_valid), 32'd1);
         check("ld_memread_cycles", 32'(n), v.oor ? 32'd0 : 32'd3);
         check("ld_resp_data", 32'(resp_data), 32'(v.exp_data));
         check("ld_resp_tag", 32'(resp_tag), 32'(v.tag));
         check("ld_resp_err", 32'(resp_err), 32'(v.oor));
         check("ld_ready_low", 32'(req_ready), 32'd0);
         check("ld_busy", 32'(busy), 32'd1);
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
         check("ld_resp_cleared", 32'(resp_valid), 32'd0);
         check("ld_err_cleared", 32'(resp_err), 32'd0);
         check("ld_ready_back", 32'(req_ready), 32'd1);
         check("ld_idle", 32'(busy), 32'd0);
         check("ld_rd_count", 32'(rd_cnt), 32'(r0 + (v.oor ? 0 : 3)));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w0, r1;
      for (int i = 0; i < 100; i++) mem[i] = 16'(i + 15);
      //           wr    addr      wdata     tag   oor   exp_data
      vecs[0] = '{1'b1, 16'd5,    16'h0012, 3'd0, 1'b0, 16'h0000};
      vecs[1] = '{1'b0, 16'd2,    16'h0000, 3'd4, 1'b0, 16'h0011};
      vecs[2] = '{1'b0, 16'd5,    16'h0000, 3'd1, 1'b0, 16'h0012};
      vecs[3] = '{1'b0, 16'd100,  16'h0000, 3'd6, 1'b1, 16'h0000};
      vecs[4] = '{1'b1, 16'hFFFF, 16'hBEEF, 3'd0, 1'b1, 16'h0000};
      vecs[5] = '{1'b1, 16'd99,   16'hA5A5, 3'd0, 1'b0, 16'h0000};
      vecs[6] = '{1'b0, 16'd99,   16'h0000, 3'd7, 1'b0, 16'hA5A5};
      vecs[7] = '{1'b0, 16'd0,    16'h0000, 3'd0, 1'b0, 16'h000F};
      vecs[8] = '{1'b0, 16'hFFFF, 16'h0000, 3'd3, 1'b1, 16'h0000};
      vecs[9] = '{1'b1, 16'd100,  16'h1234, 3'd0, 1'b1, 16'h0000};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_tag    = '0;
      resp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_address", 32'(mem_address), 32'd0);
      check("rst_datawrite", 32'(mem_datawrite), 32'd0);
      check("rst_strobes", 32'({mem_memwrite, mem_memread}), 32'd0);
      check("rst_resp", 32'({resp_valid, resp_err, store_err}), 32'd0);
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);
      check("mem99_model", 32'(mem[99]), 32'h0000A5A5);

      // Backpressure: response held for 5 cycles while a store is offered and ignored.
      w0 = wr_cnt;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'd3;
      req_tag   = 3'd2;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
      r1 = rd_cnt;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'd1;
      req_wdata = 16'h7777;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_data", 32'(resp_data), 32'h00000012);
         check("bp_tag", 32'(resp_tag), 32'd2);
         check("bp_ready_low", 32'(req_ready), 32'd0);
         check("bp_strobes", 32'({mem_memwrite, mem_memread}), 32'd0);
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("bp_released", 32'(resp_valid), 32'd0);
      check("bp_ready_back", 32'(req_ready), 32'd1);
      check("bp_no_write", 32'(wr_cnt), 32'(w0));
      check("bp_no_read", 32'(rd_cnt), 32'(r1));
      check("bp_mem1", 32'(mem[1]), 32'h00000010);

      // Reset in the middle of a read wait.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'd10;
      req_tag   = 3'd5;
      @(negedge clk);
      req_valid = 1'b0;
      check("rm_memread_on", 32'(mem_memread), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rm_memread_off", 32'(mem_memread), 32'd0);
      check("rm_resp_valid", 32'(resp_valid), 32'd0);
      check("rm_req_ready", 32'(req_ready), 32'd1);
      check("rm_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rm_no_resp", 32'({resp_valid, mem_memread, busy}), 32'd0);
      end

      check("no_overlap", 32'(overlap), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the pipeline MEM stage and drives datamem's address/datawrite/memwrite/memread.
- For loads, captures readdata after a fixed memory latency and returns it with the destination register tag to writeback.
- Rejects out-of-range addresses without touching memory.
- Sits between the EX/MEM pipeline register and datamem.

Parameters:
- ADDR_W, 16, width of the word address.
- DATA_W, 16, data word width.
- MEM_DEPTH, 100, number of valid memory words; addresses >= MEM_DEPTH are out of range.
- MEM_LAT, 1, cycles from memread assertion to valid mem_readdata (1..7).
- TAG_W, 3, width of the destination register tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_tag  in  TAG_W  load destination register.
- mem_address  out  ADDR_W  to datamem address.
- mem_datawrite  out  DATA_W  to datamem datawrite.
- mem_memwrite  out  1  to datamem memwrite.
- mem_memread  out  1  to datamem memread.
- mem_readdata  in  DATA_W  from datamem readdata.
- resp_valid  out  1  load result available.
- resp_ready  in  1  writeback accepts result.
- resp_data  out  DATA_W  load data.
- resp_tag  out  TAG_W  load destination tag.
- resp_err  out  1  load was out of range; resp_data is 0.
- store_err  out  1  one-cycle pulse: store dropped (out of range).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, except req_ready = 1; FSM to IDLE; latency counter to 0; captured address, data and tag to 0.
- rst mid-operation aborts immediately. memwrite and memread drop on the next edge, and any pending response is discarded.
- A request is accepted on a rising edge with req_valid & req_ready. req_ready = 1 only in IDLE. The request is latched into internal registers.
- FSM states: IDLE, WRITE, READ_WAIT, RESP.
- IDLE + accepted store, in range -> WRITE. In the next cycle:
  - mem_memwrite = 1 for exactly one cycle.
  - mem_address and mem_datawrite hold the latched values.
  - Return to IDLE; the store is complete.
- IDLE + accepted store, out of range -> stay IDLE; store_err pulses 1 for one cycle; no memory strobe.
- IDLE + accepted load, in range -> READ_WAIT:
  - mem_memread = 1 and mem_address held for MEM_LAT cycles; the counter runs from MEM_LAT-1 down to 0.
  - On the cycle the counter is 0, mem_readdata is registered into resp_data and the FSM goes to RESP.
- IDLE + accepted load, out of range -> RESP directly with resp_data = 0 and resp_err = 1; no memory strobe.
- RESP: resp_valid = 1; resp_data, resp_tag and resp_err are held stable until resp_valid & resp_ready. Then:
  - return to IDLE;
  - resp_valid and resp_err clear on that edge.
- Throughput:
  - Store: 2 cycles, accept to next req_ready.
  - Load: 1 + MEM_LAT cycles to resp_valid, plus the backpressure wait.
  - No overlapping requests.
- mem_memwrite and mem_memread are never 1 in the same cycle. Both are 0 in IDLE and RESP.
- mem_address and mem_datawrite hold their last values outside active cycles (no glitching to 0); after reset they are 0.
- Range check is unsigned: req_addr < MEM_DEPTH; address MEM_DEPTH-1 is valid.
- req_* inputs are ignored whenever req_ready = 0.

Test Plan:
- Reset: drive rst for 2 cycles during READ_WAIT -> the cycle after rst, mem_memread = 0, resp_valid = 0, req_ready = 1, busy = 0.
- Store: addr 5, data 0x0012 -> next cycle memwrite = 1 with address 5 and datawrite 0x0012 for exactly 1 cycle, then req_ready = 1; later load from addr 5 returns 0x0012.
- Load with MEM_LAT = 3: addr 2, tag 4, model returns 0x0011 -> memread high exactly 3 cycles, then resp_valid = 1 with resp_data 0x0011, resp_tag 4, resp_err 0.
- Backpressure: hold resp_ready = 0 for 5 cycles after resp_valid -> data and tag stable, req_ready = 0, no new memory strobes; release -> IDLE the next cycle.
- Out-of-range cases:
  - load addr 100 -> resp_valid with resp_data 0, resp_err 1, memread never asserted;
  - store addr 0xFFFF -> store_err pulses once, memwrite never asserted.
- Boundary plus back-to-back: store to addr 99 immediately followed by a load from 99 -> load returns the stored value; memwrite and memread are never both high.
